// File: rtl/stack_seq_if.sv
// Byte-wide memory handshake between the push/pull sequencer and the data bus.
// The sequencer (master) raises mem_req and holds mem_addr, mem_we and
// mem_data_out steady until the memory (slave) answers with mem_ack.
interface stack_seq_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_out;
  logic [7:0]  mem_data_in;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_data_out,
    input  mem_data_in, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_data_out,
    output mem_data_in, mem_ack
  );
endinterface

// File: rtl/stack_seq.sv
// stack_seq: PSHS/PSHU/PULS/PULU sequencer for the 6809 core.
// Walks the postbyte register mask (push b7->b0, pull b0->b7), moving each
// byte over a req/ack bus and strobing the stack pointer once per byte.
// Build option STACK_SEQ_FASTSCAN_EN: NEXT jumps straight to the next set bit
// with a priority encoder; without it a 3-bit pointer examines one bit per
// NEXT cycle.
module stack_seq (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               start,
  input  logic               is_pull,
  input  logic               use_s_in,
  input  logic [7:0]         postbyte,
  input  logic [15:0]        reg_su,
  input  logic [15:0]        path_left_data,
  stack_seq_if.master        bus,
  output logic               busy,
  output logic               done,
  output logic               use_s,
  output logic [3:0]         path_left_addr,
  output logic [3:0]         write_reg_addr,
  output logic               write_pull_reg,
  output logic [15:0]        data_w,
  output logic               inc_su,
  output logic               dec_su
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_NEXT  = 3'd1,
    ST_BYTE0 = 3'd2,
    ST_BYTE1 = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  mask_q, mask_d;
  logic        pull_q, pull_d;
  logic        use_s_q, use_s_d;
  logic [3:0]  code_q, code_d;
  logic        wide_q, wide_d;
  logic [7:0]  hi_q, hi_d;
`ifndef STACK_SEQ_FASTSCAN_EN
  logic [2:0]  step_q, step_d;
  logic        last_q, last_d;
`endif

  logic [2:0]  sel_bit;
  logic        found;
  logic        in_byte;
  logic        reg_end;

  // Postbyte bit -> register code; b6 names the stack we are not using.
  function automatic logic [3:0] bit_code(input logic [2:0] b, input logic s);
    case (b)
      3'd7:    bit_code = 4'd5;
      3'd6:    bit_code = s ? 4'd3 : 4'd4;
      3'd5:    bit_code = 4'd2;
      3'd4:    bit_code = 4'd1;
      3'd3:    bit_code = 4'd11;
      3'd2:    bit_code = 4'd9;
      3'd1:    bit_code = 4'd8;
      default: bit_code = 4'd10;
    endcase
  endfunction

  // Pick the bit examined in NEXT and whether it is selected.
`ifdef STACK_SEQ_FASTSCAN_EN
  always_comb begin
    sel_bit = 3'd0;
    if (pull_q) begin
      for (int i = 7; i >= 0; i--)
        if (mask_q[i]) sel_bit = 3'(i);
    end else begin
      for (int i = 0; i < 8; i++)
        if (mask_q[i]) sel_bit = 3'(i);
    end
    found = |mask_q;
  end
`else
  always_comb begin
    sel_bit = pull_q ? step_q : ~step_q;
    found   = mask_q[sel_bit];
  end
`endif

  assign in_byte = (state_q == ST_BYTE0) || (state_q == ST_BYTE1);
  // Current register finishes on this cycle's ack.
  assign reg_end = bus.mem_ack &&
                   (((state_q == ST_BYTE0) && !wide_q) || (state_q == ST_BYTE1));

  // Next-state and latch update logic.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    pull_d  = pull_q;
    use_s_d = use_s_q;
    code_d  = code_q;
    wide_d  = wide_q;
    hi_d    = hi_q;
`ifndef STACK_SEQ_FASTSCAN_EN
    step_d  = step_q;
    last_d  = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d  = postbyte;
          pull_d  = is_pull;
          use_s_d = use_s_in;
`ifndef STACK_SEQ_FASTSCAN_EN
          step_d  = 3'd0;
          last_d  = 1'b0;
`endif
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
`ifndef STACK_SEQ_FASTSCAN_EN
        step_d = step_q + 3'd1;
        last_d = (step_q == 3'd7);
`endif
        if (found) begin
          code_d  = bit_code(sel_bit, use_s_q);
          wide_d  = sel_bit[2];
          mask_d  = mask_q & ~(8'd1 << sel_bit);
          state_d = ST_BYTE0;
        end else begin
`ifdef STACK_SEQ_FASTSCAN_EN
          state_d = ST_DONE;
`else
          if (step_q == 3'd7) state_d = ST_DONE;
`endif
        end
      end
      ST_BYTE0, ST_BYTE1: begin
        if ((state_q == ST_BYTE0) && bus.mem_ack && wide_q) begin
          hi_d    = bus.mem_data_in;
          state_d = ST_BYTE1;
        end
        if (reg_end) begin
`ifdef STACK_SEQ_FASTSCAN_EN
          state_d = ST_NEXT;
`else
          state_d = last_q ? ST_DONE : ST_NEXT;
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latch registers with asynchronous abort.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      mask_q  <= 8'h00;
      pull_q  <= 1'b0;
      use_s_q <= 1'b0;
      code_q  <= 4'd0;
      wide_q  <= 1'b0;
      hi_q    <= 8'h00;
`ifndef STACK_SEQ_FASTSCAN_EN
      step_q  <= 3'd0;
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pull_q  <= pull_d;
      use_s_q <= use_s_d;
      code_q  <= code_d;
      wide_q  <= wide_d;
      hi_q    <= hi_d;
`ifndef STACK_SEQ_FASTSCAN_EN
      step_q  <= step_d;
      last_q  <= last_d;
`endif
    end
  end

  // Bus and register-block outputs, decoded from state and latches.
  always_comb begin
    busy             = (state_q != ST_IDLE);
    done             = (state_q == ST_DONE);
    use_s            = use_s_q;
    path_left_addr   = in_byte ? code_q : 4'd0;
    write_reg_addr   = in_byte ? code_q : 4'd0;
    bus.mem_req      = in_byte;
    bus.mem_we       = in_byte && !pull_q;
    bus.mem_addr     = 16'h0000;
    bus.mem_data_out = 8'h00;
    if (in_byte)
      bus.mem_addr = pull_q ? reg_su : (reg_su - 16'd1);
    if (in_byte && !pull_q)
      bus.mem_data_out = (state_q == ST_BYTE0) ? path_left_data[7:0]
                                               : path_left_data[15:8];
    dec_su         = in_byte && !pull_q && bus.mem_ack;
    inc_su         = in_byte &&  pull_q && bus.mem_ack;
    write_pull_reg = pull_q && reg_end;
    data_w         = 16'h0000;
    if (write_pull_reg)
      data_w = (state_q == ST_BYTE1) ? {hi_q, bus.mem_data_in}
                                     : {8'h00, bus.mem_data_in};
  end

endmodule

// File: tb/tb_stack_seq.sv
// Directed bench for stack_seq: small memory/register-block model, event log
// captured on each clock edge, expectations hand-computed per sequence.
module tb_stack_seq;

`ifdef STACK_SEQ_FASTSCAN_EN
  localparam int L_A = 4, L_PC = 5, L_PC_SLOW = 11, L_ZERO = 2;
`else
  localparam int L_A = 10, L_PC = 11, L_PC_SLOW = 17, L_ZERO = 9;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_pull = 1'b0;
  logic        use_s_in = 1'b0;
  logic [7:0]  postbyte = 8'h00;
  logic [15:0] reg_su;
  logic [15:0] path_left_data;
  logic        busy, done, use_s, write_pull_reg, inc_su, dec_su;
  logic [3:0]  path_left_addr, write_reg_addr;
  logic [15:0] data_w;

  stack_seq_if bus ();

  stack_seq dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .start          (start),
    .is_pull        (is_pull),
    .use_s_in       (use_s_in),
    .postbyte       (postbyte),
    .reg_su         (reg_su),
    .path_left_data (path_left_data),
    .bus            (bus),
    .busy           (busy),
    .done           (done),
    .use_s          (use_s),
    .path_left_addr (path_left_addr),
    .write_reg_addr (write_reg_addr),
    .write_pull_reg (write_pull_reg),
    .data_w         (data_w),
    .inc_su         (inc_su),
    .dec_su         (dec_su)
  );

  always #5 clk = ~clk;

  // Memory, register file and stack-pointer model
  logic [7:0]  ram  [0:65535];
  logic [15:0] regs [0:15];
  logic [15:0] sp_base = 16'h0000;
  logic [15:0] sp_delta = 16'h0000;
  int          ack_delay = 0;
  int          wait_n = 0;

  assign reg_su          = sp_base + sp_delta;
  assign path_left_data  = regs[path_left_addr];
  assign bus.mem_data_in = ram[bus.mem_addr];
  assign bus.mem_ack     = bus.mem_req && (wait_n >= ack_delay);

  // Event log (cumulative counters; tests work on deltas)
  int          cyc = 0, done_n = 0, done_cyc = 0;
  int          wr_n = 0, rw_n = 0, dec_n = 0, inc_n = 0, unstable_n = 0, bad_n = 0;
  logic [15:0] wr_addr [0:63];
  logic [7:0]  wr_data [0:63];
  logic [3:0]  rw_addr [0:63];
  logic [15:0] rw_data [0:63];
  logic        req_hold = 1'b0;
  logic [24:0] hold_val = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    wait_n <= (bus.mem_req && !bus.mem_ack) ? wait_n + 1 : 0;
    if (dec_su) begin sp_delta <= sp_delta - 16'd1; dec_n <= dec_n + 1; end
    if (inc_su) begin sp_delta <= sp_delta + 16'd1; inc_n <= inc_n + 1; end
    if (bus.mem_req && bus.mem_we && bus.mem_ack) begin
      wr_addr[wr_n[5:0]] <= bus.mem_addr;
      wr_data[wr_n[5:0]] <= bus.mem_data_out;
      wr_n <= wr_n + 1;
    end
    if (write_pull_reg) begin
      rw_addr[rw_n[5:0]] <= write_reg_addr;
      rw_data[rw_n[5:0]] <= data_w;
      rw_n <= rw_n + 1;
    end
    if (done) begin done_n <= done_n + 1; done_cyc <= cyc; end
    if (bus.mem_req && req_hold &&
        ({bus.mem_we, bus.mem_addr, bus.mem_data_out} != hold_val))
      unstable_n <= unstable_n + 1;
    if ((dec_su || inc_su) && !bus.mem_ack) bad_n <= bad_n + 1;
    req_hold <= bus.mem_req && !bus.mem_ack;
    hold_val <= {bus.mem_we, bus.mem_addr, bus.mem_data_out};
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_sp(input logic [15:0] v);
    @(negedge clk);
    sp_base = v - sp_delta;
  endtask

  // Launch one sequence and wait (bounded) for done; returns latency in cycles.
  task automatic run_seq(input logic pull, input logic s, input logic [7:0] pb,
                         input logic poke, output int lat);
    int s_cyc;
    int d0;
    d0 = done_n;
    @(negedge clk);
    start = 1'b1; is_pull = pull; use_s_in = s; postbyte = pb;
    @(posedge clk);
    s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      postbyte = 8'hFF; is_pull = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 300 && done_n == d0; i++) @(negedge clk);
    if (done_n == d0) begin
      check("done_timeout", 32'd0, 32'd1);
      lat = -1;
    end else begin
      lat = done_cyc - s_cyc;
    end
    $display("seq pull=%0d use_s=%0d postbyte=%02h latency=%0d", pull, s, pb, lat);
  endtask

  int lat, w0, r0, d0, i0, u0, b0, dn0;
  logic found;

  initial begin
    regs[5] = 16'h1234;   // PC
    regs[8] = 16'h005A;   // A
    ram[16'h0E00] = 8'hC5;
    ram[16'h0E01] = 8'h0F;
    ram[16'h0E02] = 8'h00;

    // Reset state
    @(negedge clk);
    check("rst_ctrl", {busy, done, use_s, bus.mem_req, bus.mem_we, dec_su, inc_su, write_pull_reg}, 8'h00);
    check("rst_addr", bus.mem_addr, 16'h0000);
    check("rst_data_w", data_w, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // PSHS A
    set_sp(16'h0F00);
    w0 = wr_n; d0 = dec_n;
    run_seq(1'b0, 1'b1, 8'h02, 1'b0, lat);
    check("pshs_a_nwr", wr_n - w0, 1);
    check("pshs_a_addr", wr_addr[w0[5:0]], 16'h0EFF);
    check("pshs_a_data", wr_data[w0[5:0]], 8'h5A);
    check("pshs_a_dec", dec_n - d0, 1);
    check("pshs_a_sp", reg_su, 16'h0EFF);
    check("pshs_a_lat", lat, L_A);

    // PSHS PC
    set_sp(16'h0F00);
    w0 = wr_n; d0 = dec_n;
    run_seq(1'b0, 1'b1, 8'h80, 1'b0, lat);
    check("pshs_pc_nwr", wr_n - w0, 2);
    check("pshs_pc_lo", {wr_addr[w0[5:0]], wr_data[w0[5:0]]}, 24'h0EFF34);
    check("pshs_pc_hi", {wr_addr[w0[5:0] + 6'd1], wr_data[w0[5:0] + 6'd1]}, 24'h0EFE12);
    check("pshs_pc_dec", dec_n - d0, 2);
    check("pshs_pc_lat", lat, L_PC);

    // PULU CC,S
    set_sp(16'h0E00);
    r0 = rw_n; i0 = inc_n;
    run_seq(1'b1, 1'b0, 8'h41, 1'b0, lat);
    check("pulu_nrw", rw_n - r0, 2);
    check("pulu_cc", {rw_addr[r0[5:0]], rw_data[r0[5:0]]}, {4'd10, 16'h00C5});
    check("pulu_s", {rw_addr[r0[5:0] + 6'd1], rw_data[r0[5:0] + 6'd1]}, {4'd4, 16'h0F00});
    check("pulu_inc", inc_n - i0, 3);
    check("pulu_sp", reg_su, 16'h0E03);

    // PULS U (b6 names U on the S stack)
    set_sp(16'h0E01);
    r0 = rw_n;
    run_seq(1'b1, 1'b1, 8'h40, 1'b0, lat);
    check("puls_u", {rw_addr[r0[5:0]], rw_data[r0[5:0]]}, {4'd3, 16'h0F00});
    check("puls_use_s", use_s, 1'b1);

    // Stack wrap
    set_sp(16'h0000);
    w0 = wr_n;
    run_seq(1'b0, 1'b1, 8'h02, 1'b0, lat);
    check("wrap_addr", wr_addr[w0[5:0]], 16'hFFFF);
    check("wrap_sp", reg_su, 16'hFFFF);

    // Slow memory: ack three cycles late on every byte
    ack_delay = 3;
    set_sp(16'h0F00);
    w0 = wr_n; d0 = dec_n; u0 = unstable_n; b0 = bad_n;
    run_seq(1'b0, 1'b1, 8'h80, 1'b0, lat);
    check("slow_nwr", wr_n - w0, 2);
    check("slow_hi", {wr_addr[w0[5:0] + 6'd1], wr_data[w0[5:0] + 6'd1]}, 24'h0EFE12);
    check("slow_dec", dec_n - d0, 2);
    check("slow_stable", unstable_n - u0, 0);
    check("slow_strobe", bad_n - b0, 0);
    check("slow_lat", lat, L_PC_SLOW);

    // Empty mask with a stray start while busy
    ack_delay = 0;
    w0 = wr_n; dn0 = done_n;
    run_seq(1'b0, 1'b1, 8'h00, 1'b1, lat);
    check("zero_lat", lat, L_ZERO);
    repeat (25) @(negedge clk);
    check("zero_ndone", done_n - dn0, 1);
    check("zero_nwr", wr_n - w0, 0);
    check("zero_idle", busy, 1'b0);

    // Reset during BYTE1 of a push
    ack_delay = 3;
    set_sp(16'h0F00);
    @(negedge clk);
    start = 1'b1; is_pull = 1'b0; use_s_in = 1'b1; postbyte = 8'h80;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.mem_req && bus.mem_addr == 16'h0EFE) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("abort_reach_byte1", found, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_ctrl", {busy, done, use_s, bus.mem_req, bus.mem_we, dec_su, inc_su, write_pull_reg}, 8'h00);
    check("abort_bus", {bus.mem_addr, bus.mem_data_out}, 24'h000000);
    check("abort_sp_kept", reg_su, 16'h0EFF);
    $display("abort reset asserted at cycle %0d", cyc);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 0;
    set_sp(16'h0F00);
    w0 = wr_n;
    run_seq(1'b0, 1'b1, 8'h02, 1'b0, lat);
    check("after_abort_wr", {wr_addr[w0[5:0]], wr_data[w0[5:0]]}, 24'h0EFF5A);
    check("after_abort_lat", lat, L_A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_seq.md
# stack_seq

Push/pull sequencer for the 6809 core's PSHS/PSHU/PULS/PULU instructions. It takes the register-mask postbyte from the decoder and walks the selected registers in 6809 order. Each byte moves through a req/ack memory handshake. The block drives the register block's read path, write port and `inc_su`/`dec_su` strobes. It sits between the instruction decoder/fetch stage and the register block, and owns the bus only while `busy` is high.

## Interface
Parameters: none.

Ports:
- clk_in  in  1  system clock, all state updates on rising edge
- rst_n_in  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- is_pull  in  1  latched at start: 1 = pull, 0 = push
- use_s_in  in  1  latched at start: 1 = S stack, 0 = U stack
- postbyte  in  8  latched at start; b7 PC, b6 U/S (other stack), b5 Y, b4 X, b3 DP, b2 B, b1 A, b0 CC
- reg_su  in  16  current selected stack pointer from register block
- path_left_data  in  16  register read data for the register named by `path_left_addr`
- mem_data_in  in  8  read data, valid when `mem_ack`=1
- mem_ack  in  1  memory completes the current transfer this cycle
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at end of sequence
- use_s  out  1  latched stack select, to register block
- path_left_addr  out  4  register code of the current register
- write_reg_addr  out  4  same code as `path_left_addr`
- write_pull_reg  out  1  register write strobe (pull only)
- data_w  out  16  register write data
- inc_su, dec_su  out  1  stack pointer strobes
- mem_req, mem_we  out  1  bus request / write
- mem_addr  out  16  bus address
- mem_data_out  out  8  write data

Register codes: D 0, X 1, Y 2, U 3, S 4, PC 5, A 8, B 9, CC 10, DP 11.

## Operation
- States: IDLE, NEXT, BYTE0, BYTE1, DONE.
- IDLE, start=1: latch `postbyte` into the remaining-mask, latch `is_pull` and `use_s_in`, go to NEXT.
- Scan order:
  - Push scans b7 to b0.
  - Pull scans b0 to b7.
  - b6 selects U when `use_s`=1, otherwise S.
- NEXT, a set bit is found:
  - Select that register, clear its bit in the mask.
  - Go to BYTE0.
- NEXT, mask is empty: go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- BYTE0 / BYTE1 each hold `mem_req`=1 until `mem_ack`.
  - 8-bit registers use BYTE0 only, then return to NEXT.
  - 16-bit registers use BYTE0 then BYTE1.
- Push byte cycle:
  - `mem_we`=1, `mem_addr` = `reg_su` − 1 (mod 2^16).
  - `dec_su`=1 only in the ack cycle.
  - Byte order: low byte in BYTE0, high byte in BYTE1.
- Pull byte cycle:
  - `mem_we`=0, `mem_addr` = `reg_su`.
  - `inc_su`=1 only in the ack cycle.
  - 16-bit: BYTE0 captures the high byte into an internal register. BYTE1 on ack asserts `write_pull_reg` with `data_w` = {hi, `mem_data_in`}.
  - 8-bit: BYTE0 on ack asserts `write_pull_reg` with `data_w` = {8'h00, `mem_data_in`}.
- `start` outside IDLE is ignored.
- All strobes are 0 outside their qualifying cycle.

## Timing
- All state and latches are registered.
- Memory-facing and register-facing outputs are combinational from state, latches, `mem_ack` and `reg_su`.
- `mem_ack` may arrive in the same cycle `mem_req` rises (zero wait) or any number of cycles later.
- `mem_addr`, `mem_we` and `mem_data_out` are stable while `mem_req` is held.
- `busy` is 1 in NEXT, BYTE0, BYTE1 and DONE.
- Reset values: state IDLE, mask 0, all outputs 0.
- Reset asserted mid-sequence aborts immediately. Stack-pointer changes already made are not undone.
- Stack wrap: `reg_su`=0x0000 on push gives `mem_addr`=0xFFFF.

## Configuration
- `STACK_SEQ_FASTSCAN_EN` defined:
  - NEXT uses a priority encoder and jumps to the next set bit in one cycle.
  - Zero-mask sequence: `done` 2 cycles after the start edge.
- `STACK_SEQ_FASTSCAN_EN` undefined:
  - A 3-bit pointer examines one bit per NEXT cycle, in scan order.
  - DONE is entered after the last bit position is examined.
  - Zero-mask sequence: `done` 9 cycles after the start edge.

## Test plan
- PSHS postbyte 0x02, A=0x5A, S=0x0F00, ack tied high → one write 0x5A at 0x0EFF with `dec_su`. Fastscan: `done` in cycle 4.
- PSHS 0x80, PC=0x1234, S=0x0F00 → write 0x34 @0x0EFF, then 0x12 @0x0EFE, two `dec_su` pulses.
- PULU 0x41, U=0x0E00, mem[0x0E00]=0xC5, mem[0x0E01]=0x0F, mem[0x0E02]=0x00 → CC (code 10) ← 0x00C5, then S (code 4) ← 0x0F00, three `inc_su` pulses.
- `mem_ack` delayed 3 cycles per byte → `mem_req`/`mem_addr` held steady, exactly one `dec_su` per byte.
- Zero postbyte, and `start` pulsed while busy → `done` at 2 cycles (fastscan) or 9 cycles (no fastscan); the extra start is ignored.
- `rst_n_in` low during BYTE1 of a push → all outputs 0 immediately; next start runs normally.
